rv32_store_drain_ctrl: RTL and testbench
========================================

# rv32_store_drain_ctrl

Store-buffer controller for the RV32 data-memory port.
- Accepts full-word stores from the core into a small circular queue.
- Drains the queue to data memory through a req/ack handshake, one store at a time, oldest first.
- Gives loads a same-cycle forwarding lookup: the youngest pending store to the same address supplies the load data.
- Sits between the execute stage and the data-memory interface, and sequences the delayed writes that the load/store forwarding path depends on.

## Interface
- DEPTH, 4, queue entries; power of two, ≥2
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- st_valid  in  1  core presents a store this cycle
- st_addr  in  32  store word address (bits [1:0] ignored, treated as 0)
- st_data  in  32  store data, full word
- st_ready  out  1  queue can accept a store; = (count != DEPTH)
- ld_addr  in  32  load lookup address (bits [1:0] ignored)
- ld_mem_data  in  32  load data read from memory this cycle
- ld_data  out  32  forwarded data if ld_hit, else ld_mem_data
- ld_hit  out  1  ld_addr matches a pending entry
- mem_req  out  1  write request to data memory
- mem_addr  out  32  head entry address, {addr[31:2],2'b00}
- mem_wdata  out  32  head entry data
- mem_ack  in  1  memory accepted the write this cycle
- count  out  $clog2(DEPTH)+1  entries pending
- empty  out  1  count == 0

## Operation
- **Queue:** entries in registers; wr_ptr, rd_ptr wrap modulo DEPTH; count is held explicitly (no ptr-compare full/empty).
- **Enqueue:** st_valid && st_ready writes the entry at wr_ptr, then wr_ptr+1. st_valid while full is ignored; the core must hold the store.
- **Drain FSM:** two states, IDLE and REQ; mem_req = (state == REQ).
  - IDLE -> REQ when count > 0.
  - REQ: mem_addr and mem_wdata come from the rd_ptr entry and stay stable until mem_ack.
  - On mem_ack: pop (rd_ptr+1). Stay in REQ if count after the pop is > 0; otherwise go to IDLE.
- **mem_ack outside REQ:** ignored, no pop.
- **Simultaneous enqueue and pop:** count unchanged, both pointers advance.
- **Full queue with mem_ack:** st_ready stays 0 that cycle (no same-cycle bypass). It rises the next cycle.
- **Forwarding:** combinational compare of ld_addr[31:2] against every valid entry at cycle start.
  - The youngest match (closest to wr_ptr-1) wins.
  - The entry being popped this cycle still participates in the compare.
  - A store being enqueued this cycle does not participate.
- **No forwarding when empty:** ld_hit = 0 and ld_data = ld_mem_data.

## Timing
- **Reset values (asynchronous, immediate):** state IDLE, pointers 0, count 0, mem_req 0, empty 1, st_ready 1, ld_hit 0.
  - Reset mid-drain discards all pending stores.
  - mem_req drops with rst_n low.
- **Enqueue-to-request latency:** store accepted at edge t (queue empty, IDLE) -> state REQ at edge t+1 -> mem_req high in the cycle after t+1.
- **Throughput:** with mem_ack held high, REQ drains one entry per cycle with no IDLE bubble between entries.
- **Drain to empty:** mem_req falls in the cycle after the final ack.
- **Outputs:** count, empty and st_ready are registered-derived and change only on clk edges or reset. ld_hit and ld_data are combinational from ld_addr and ld_mem_data.

## Test plan
- **Reset mid-drain:** load 3 stores, assert rst_n=0 during REQ -> mem_req=0, count=0, empty=1, st_ready=1 immediately; no further writes after release.
- **Single store:** st_addr=0x100, st_data=0xDEADBEEF at edge 0, mem_ack=1 -> mem_req high after edge 1 with mem_addr=0x100, mem_wdata=0xDEADBEEF; empty=1 after the ack edge.
- **Fill to full:** 4 stores with mem_ack=0 -> st_ready=0, count=4, a 5th st_valid is ignored.
  - Then one mem_ack -> count=3, st_ready=1 next cycle.
  - Drain order must equal enqueue order.
- **Youngest match wins:** 0x200<-0x11, then 0x204<-0x22, then 0x200<-0x33 pending; ld_addr=0x202 -> ld_hit=1, ld_data=0x33. ld_addr=0x300 -> ld_hit=0, ld_data=ld_mem_data.
- **Simultaneous push and pop:** DEPTH-1 entries, st_valid and mem_ack in the same cycle -> count unchanged.
  - Pointer wrap past DEPTH-1 is correct.
  - The popped entry still forwards in its ack cycle.
- **Continuous drain:** 4 stores enqueued back-to-back, mem_ack held 1 -> four consecutive mem_req cycles, no gap, addresses in order.

Source files
------------

// File: rtl/rv32_store_drain_ctrl.sv
// Store buffer between execute and the data-memory write port: queues full-word
// stores, drains them oldest-first over req/ack, and forwards the youngest match to loads.
module rv32_store_drain_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     st_valid,
    input  logic [31:0]              st_addr,
    input  logic [31:0]              st_data,
    output logic                     st_ready,
    input  logic [31:0]              ld_addr,
    input  logic [31:0]              ld_mem_data,
    output logic [31:0]              ld_data,
    output logic                     ld_hit,
    output logic                     mem_req,
    output logic [31:0]              mem_addr,
    output logic [31:0]              mem_wdata,
    input  logic                     mem_ack,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] REQ  = 1'b1;

    logic [29:0]   addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [0:0]    state;
    logic          push;
    logic          pop;
    logic          unused_low_bits;

    // Word addressing: the byte-offset bits never take part in storage or compare.
    assign unused_low_bits = ^{st_addr[1:0], ld_addr[1:0]};

    assign st_ready  = (cnt != CW'(DEPTH));
    assign empty     = (cnt == '0);
    assign count     = cnt;
    assign mem_req   = (state == REQ);
    assign mem_addr  = {addr_q[rd_ptr], 2'b00};
    assign mem_wdata = data_q[rd_ptr];

    assign push = st_valid && st_ready;
    assign pop  = (state == REQ) && mem_ack;

    always_comb begin
        cnt_nxt = cnt;
        case ({push, pop})
            2'b10:   cnt_nxt = cnt + CW'(1);
            2'b01:   cnt_nxt = cnt - CW'(1);
            default: cnt_nxt = cnt;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            cnt <= cnt_nxt;
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case (state)
                IDLE:    if (cnt != '0) state <= REQ;
                REQ:     if (mem_ack) state <= (cnt_nxt != '0) ? REQ : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Entry storage carries no reset; validity is tracked solely by rd_ptr/cnt.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr] <= st_addr[31:2];
            data_q[wr_ptr] <= st_data;
        end
    end

    // Walk oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        logic [AW-1:0] idx;
        ld_hit  = 1'b0;
        ld_data = ld_mem_data;
        idx     = rd_ptr;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + AW'(i);
            if ((CW'(i) < cnt) && (addr_q[idx] == ld_addr[31:2])) begin
                ld_hit  = 1'b1;
                ld_data = data_q[idx];
            end
        end
    end

endmodule

// File: tb/tb_rv32_store_drain_ctrl.sv
// Bench for rv32_store_drain_ctrl: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_rv32_store_drain_ctrl;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_ready;
    logic [31:0] ld_addr;
    logic [31:0] ld_mem_data;
    logic [31:0] ld_data;
    logic        ld_hit;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [$clog2(DEPTH):0] count;
    logic        empty;

    int total = 0;
    int bad   = 0;

    rv32_store_drain_ctrl #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
        .ld_addr(ld_addr), .ld_mem_data(ld_mem_data), .ld_data(ld_data), .ld_hit(ld_hit),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: pending stores oldest-first, plus whether a write is being offered.
    typedef struct {
        logic [29:0] a;
        logic [31:0] d;
    } ent_t;

    ent_t mq[$];
    bit   m_req = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            mq.delete();
            m_req = 0;
            chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
            chk("rst_count", {29'b0, count}, 32'd0);
            chk("rst_empty", {31'b0, empty}, 32'd1);
            chk("rst_st_ready", {31'b0, st_ready}, 32'd1);
            chk("rst_ld_hit", {31'b0, ld_hit}, 32'd0);
            chk("rst_ld_data", ld_data, ld_mem_data);
        end else begin
            int  sz;
            bit  hit;
            bit  do_push;
            bit  do_pop;
            logic [31:0] fwd;
            sz  = mq.size();
            hit = 0;
            fwd = ld_mem_data;
            for (int i = sz - 1; i >= 0; i--) begin
                if (!hit && mq[i].a == ld_addr[31:2]) begin
                    hit = 1;
                    fwd = mq[i].d;
                end
            end
            chk("count", {29'b0, count}, sz);
            chk("empty", {31'b0, empty}, (sz == 0) ? 32'd1 : 32'd0);
            chk("st_ready", {31'b0, st_ready}, (sz != DEPTH) ? 32'd1 : 32'd0);
            chk("mem_req", {31'b0, mem_req}, {31'b0, m_req});
            chk("ld_hit", {31'b0, ld_hit}, {31'b0, hit});
            chk("ld_data", ld_data, fwd);
            if (m_req) begin
                chk("mem_addr", mem_addr, {mq[0].a, 2'b00});
                chk("mem_wdata", mem_wdata, mq[0].d);
            end
            do_pop  = m_req && mem_ack;
            do_push = st_valid && (sz != DEPTH);
            if (!m_req)
                m_req = (sz > 0);
            else if (do_pop)
                m_req = (sz - 1 + int'(do_push)) > 0;
            if (do_pop)
                void'(mq.pop_front());
            if (do_push)
                mq.push_back('{a: st_addr[31:2], d: st_data});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] a, input logic [31:0] d);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0;
        ld_addr = '0; ld_mem_data = 32'h1234_5678; mem_ack = 1'b0;
        #2;
        chk("init_count", {29'b0, count}, 32'd0);
        chk("init_st_ready", {31'b0, st_ready}, 32'd1);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Reset in the middle of a drain
        put(32'h10, 32'hA1); put(32'h14, 32'hA2); put(32'h18, 32'hA3);
        st_valid = 1'b0;
        #1 chk("pre_rst_mem_req", {31'b0, mem_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_mem_req", {31'b0, mem_req}, 32'd0);
        chk("async_count", {29'b0, count}, 32'd0);
        chk("async_empty", {31'b0, empty}, 32'd1);
        chk("async_st_ready", {31'b0, st_ready}, 32'd1);
        tick();
        rst_n = 1'b1;
        mem_ack = 1'b1;
        repeat (3) begin
            tick();
            chk("post_rst_no_req", {31'b0, mem_req}, 32'd0);
        end
        mem_ack = 1'b0;

        // Single store latency
        mem_ack = 1'b1;
        put(32'h100, 32'hDEAD_BEEF);
        st_valid = 1'b0;
        chk("single_idle_cycle", {31'b0, mem_req}, 32'd0);
        tick();
        chk("single_req", {31'b0, mem_req}, 32'd1);
        chk("single_addr", mem_addr, 32'h100);
        chk("single_wdata", mem_wdata, 32'hDEAD_BEEF);
        tick();
        chk("single_empty", {31'b0, empty}, 32'd1);
        chk("single_req_fall", {31'b0, mem_req}, 32'd0);
        mem_ack = 1'b0;
        tick();

        // Fill to full, ignored 5th store, then ordered drain
        for (int i = 0; i < 4; i++) put(32'h400 + 32'(4 * i), 32'hA0 + 32'(i));
        chk("full_ready", {31'b0, st_ready}, 32'd0);
        chk("full_count", {29'b0, count}, 32'd4);
        put(32'h500, 32'hBAD);
        chk("full_ignored", {29'b0, count}, 32'd4);
        st_valid = 1'b1; st_addr = 32'h504; mem_ack = 1'b1;
        #1 chk("full_ack_ready", {31'b0, st_ready}, 32'd0);
        chk("full_head", mem_addr, 32'h400);
        tick();
        st_valid = 1'b0;
        chk("after_ack_count", {29'b0, count}, 32'd3);
        chk("after_ack_ready", {31'b0, st_ready}, 32'd1);
        for (int k = 1; k < 4; k++) begin
            chk("drain_order", mem_addr, 32'h400 + 32'(4 * k));
            tick();
        end
        mem_ack = 1'b0;
        tick();

        // Youngest match wins
        put(32'h200, 32'h11); put(32'h204, 32'h22); put(32'h200, 32'h33);
        st_valid = 1'b0;
        ld_addr = 32'h202; ld_mem_data = 32'hCAFE;
        #1;
        chk("young_hit", {31'b0, ld_hit}, 32'd1);
        chk("young_data", ld_data, 32'h33);
        ld_addr = 32'h300;
        #1;
        chk("miss_hit", {31'b0, ld_hit}, 32'd0);
        chk("miss_data", ld_data, 32'hCAFE);
        mem_ack = 1'b1;
        repeat (3) tick();
        mem_ack = 1'b0;
        tick();

        // Simultaneous push and pop across pointer wrap
        put(32'h600, 32'h60); put(32'h604, 32'h61); put(32'h608, 32'h62);
        for (int k = 0; k < 6; k++) begin
            st_valid = 1'b1; st_addr = 32'h60C + 32'(4 * k); st_data = 32'h63 + 32'(k);
            mem_ack = 1'b1; ld_addr = 32'h600 + 32'(4 * k);
            #1;
            chk("pop_entry_fwd_hit", {31'b0, ld_hit}, 32'd1);
            chk("pop_entry_fwd_data", ld_data, 32'h60 + 32'(k));
            tick();
            chk("pushpop_count", {29'b0, count}, 32'd3);
        end
        st_valid = 1'b0;
        repeat (4) tick();
        mem_ack = 1'b0;

        // Continuous drain, no bubbles
        mem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            put(32'h700 + 32'(4 * i), 32'h70 + 32'(i));
            if (i >= 1) begin
                chk("cont_req", {31'b0, mem_req}, 32'd1);
                chk("cont_addr", mem_addr, 32'h700 + 32'(4 * (i - 1)));
            end
        end
        st_valid = 1'b0;
        tick();
        chk("cont_req_last", {31'b0, mem_req}, 32'd1);
        chk("cont_addr_last", mem_addr, 32'h70C);
        tick();
        chk("cont_req_fall", {31'b0, mem_req}, 32'd0);
        mem_ack = 1'b0;

        // Randomized traffic over a small address window to provoke forwarding hits
        for (int n = 0; n < 3000; n++) begin
            st_valid    = ($urandom_range(0, 99) < 55);
            st_addr     = 32'h800 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
            st_data     = $urandom;
            mem_ack     = ($urandom_range(0, 99) < 45);
            ld_addr     = 32'h800 + 32'($urandom_range(0, 9) * 4) + 32'($urandom_range(0, 3));
            ld_mem_data = $urandom;
            tick();
        end
        st_valid = 1'b0; mem_ack = 1'b1;
        repeat (6) tick();
        chk("final_empty", {31'b0, empty}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
